// File: rtl/bin_to_bcd_seq.sv
// +--------------------------------------------------------------------------+
// | bin_to_bcd_seq : sequential double-dabble binary-to-BCD, one-hot decode   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [BIN_W-1:0]       bin_in,
   output logic                   busy,
   output logic                   done,
   output logic [4*DIGITS-1:0]    bcd_out,
   output logic [10*DIGITS-1:0]   dec_onehot,
   output logic                   overflow
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int SCR_W = 4 * DIGITS;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [BIN_W-1:0] bin_q, bin_d;
   logic [SCR_W-1:0] scr_q, scr_d;
   logic [SCR_W-1:0] scr_adj;
   logic [SCR_W-1:0] scr_next;
   logic             ovf_scr_q, ovf_scr_d;
   logic             ovf_scr_next;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SCR_W-1:0] bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;

   // Add-3 correction on every scratch digit before the shift.
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_adj
         assign scr_adj[4*i +: 4] = (scr_q[4*i +: 4] >= 4'd5) ?
                                    (scr_q[4*i +: 4] + 4'd3) : scr_q[4*i +: 4];
      end
   endgenerate

   // Bit leaving the top digit is a dropped carry: it marks overflow.
   assign scr_next     = {scr_adj[SCR_W-2:0], bin_q[BIN_W-1]};
   assign ovf_scr_next = ovf_scr_q | scr_adj[SCR_W-1];

   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      scr_d     = scr_q;
      ovf_scr_d = ovf_scr_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d     = bin_in;
               scr_d     = '0;
               ovf_scr_d = 1'b0;
               cnt_d     = CNT_LOAD;
               state_d   = S_SHIFT;
            end
         end
         S_SHIFT: begin
            scr_d     = scr_next;
            bin_d     = bin_q << 1;
            ovf_scr_d = ovf_scr_next;
            cnt_d     = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               bcd_d   = scr_next;
               ovf_d   = ovf_scr_next;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         bin_q     <= '0;
         scr_q     <= '0;
         ovf_scr_q <= 1'b0;
         cnt_q     <= '0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bin_q     <= bin_d;
         scr_q     <= scr_d;
         ovf_scr_q <= ovf_scr_d;
         cnt_q     <= cnt_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy     = (state_q == S_SHIFT);
   assign done     = done_q;
   assign bcd_out  = bcd_q;
   assign overflow = ovf_q;

   // Digit codes 10..15 match no line and decode to all zeros.
   generate
      for (genvar i = 0; i < DIGITS; i++) begin : g_dec
         for (genvar v = 0; v < 10; v++) begin : g_val
            assign dec_onehot[10*i + v] = (bcd_q[4*i +: 4] == 4'(v));
         end
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
// +--------------------------------------------------------------------------+
// | tb_bin_to_bcd_seq : scoreboard bench for bin_to_bcd_seq (3- and 2-digit)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bin_to_bcd_seq;

   typedef struct {
      logic [11:0] bcd;
      logic        ovf;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start3 = 1'b0;
   logic        start2 = 1'b0;
   logic [7:0]  bin3 = '0;
   logic [7:0]  bin2 = '0;
   logic        busy3, done3, ovf3;
   logic        busy2, done2, ovf2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;
   logic [29:0] dec3;
   logic [19:0] dec2;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic fin_req = 1'b0;
   logic fin_done = 1'b0;
   exp_t q3[$];
   exp_t q2[$];
   exp_t last3 = '{12'h000, 1'b0, 0};
   exp_t last2 = '{12'h000, 1'b0, 0};

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
      .busy(busy3), .done(done3), .bcd_out(bcd3), .dec_onehot(dec3),
      .overflow(ovf3)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
      .busy(busy2), .done(done2), .bcd_out(bcd2), .dec_onehot(dec2),
      .overflow(ovf2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [29:0] onehot(input logic [11:0] b, input int nd);
      logic [29:0] r;
      int          v;
      r = '0;
      for (int d = 0; d < nd; d++) begin
         v = int'(b[4*d +: 4]);
         if (v < 10) r[10*d + v] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: sole owner of the counters and of popping the scoreboards.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q3.delete();
         q2.delete();
         last3 = '{12'h000, 1'b0, 0};
         last2 = '{12'h000, 1'b0, 0};
         chk("rst_busy3", busy3, 0);
         chk("rst_done3", done3, 0);
         chk("rst_bcd3", bcd3, 0);
         chk("rst_ovf3", ovf3, 0);
         chk("rst_dec3", dec3, 30'h00100401);
         chk("rst_busy2", busy2, 0);
         chk("rst_done2", done2, 0);
         chk("rst_bcd2", bcd2, 0);
         chk("rst_ovf2", ovf2, 0);
         chk("rst_dec2", dec2, 20'h00401);
      end else begin
         chk("busy3", busy3, (q3.size() > 0) && (cyc < q3[0].due));
         chk("busy_done_excl3", busy3 & done3, 0);
         if (done3) begin
            if (q3.size() == 0) chk("spurious_done3", 1, 0);
            else begin
               e = q3.pop_front();
               chk("done_cycle3", cyc, e.due);
               last3 = e;
            end
         end else if ((q3.size() > 0) && (cyc >= q3[0].due)) begin
            chk("missing_done3", 0, 1);
            void'(q3.pop_front());
         end
         chk("bcd3", bcd3, last3.bcd);
         chk("ovf3", ovf3, last3.ovf);
         chk("dec3", dec3, onehot(last3.bcd, 3));

         chk("busy2", busy2, (q2.size() > 0) && (cyc < q2[0].due));
         chk("busy_done_excl2", busy2 & done2, 0);
         if (done2) begin
            if (q2.size() == 0) chk("spurious_done2", 1, 0);
            else begin
               e = q2.pop_front();
               chk("done_cycle2", cyc, e.due);
               last2 = e;
            end
         end else if ((q2.size() > 0) && (cyc >= q2[0].due)) begin
            chk("missing_done2", 0, 1);
            void'(q2.pop_front());
         end
         chk("bcd2", bcd2, last2.bcd);
         chk("ovf2", ovf2, last2.ovf);
         chk("dec2", dec2, onehot(last2.bcd, 2));

         if (fin_req && !fin_done) begin
            chk("q3_drained", q3.size(), 0);
            chk("q2_drained", q2.size(), 0);
            fin_done = 1'b1;
         end
      end
   end

   // Called #1 after an edge with the DUT idle; start is accepted at the next edge.
   task automatic conv3(input logic [7:0] v, input logic [11:0] eb, input logic eo);
      start3 = 1'b1;
      bin3   = v;
      @(posedge clk); #1;
      start3 = 1'b0;
      q3.push_back('{eb, eo, cyc + 8});
      repeat (9) @(posedge clk);
      #1;
   endtask

   task automatic conv2(input logic [7:0] v, input logic [7:0] eb, input logic eo);
      start2 = 1'b1;
      bin2   = v;
      @(posedge clk); #1;
      start2 = 1'b0;
      q2.push_back('{{4'h0, eb}, eo, cyc + 8});
      repeat (9) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      conv3(8'd255, 12'h255, 1'b0);
      conv3(8'd0,   12'h000, 1'b0);
      conv3(8'd100, 12'h100, 1'b0);

      conv2(8'd99,  8'h99, 1'b0);
      conv2(8'd100, 8'h00, 1'b1);
      conv2(8'd200, 8'h00, 1'b1);
      conv2(8'd255, 8'h55, 1'b1);
      conv2(8'd9,   8'h09, 1'b0);

      // Start while busy is ignored; start on the done cycle is accepted.
      start3 = 1'b1;
      bin3   = 8'd42;
      @(posedge clk); #1;
      start3 = 1'b0;
      q3.push_back('{12'h042, 1'b0, cyc + 8});
      repeat (3) @(posedge clk);
      #1 start3 = 1'b1; bin3 = 8'd7;
      @(posedge clk);
      #1 start3 = 1'b0;
      repeat (4) @(posedge clk);
      #1 start3 = 1'b1; bin3 = 8'd7;
      @(posedge clk); #1;
      start3 = 1'b0;
      q3.push_back('{12'h007, 1'b0, cyc + 8});
      repeat (10) @(posedge clk);
      #1;

      // Reset in the middle of a conversion: no done may follow.
      start3 = 1'b1;
      bin3   = 8'd200;
      @(posedge clk); #1;
      start3 = 1'b0;
      q3.push_back('{12'h200, 1'b0, cyc + 8});
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      conv3(8'd200, 12'h200, 1'b0);

      // All operands back to back with start held high.
      start3 = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bin3 = 8'(i);
         @(posedge clk); #1;
         q3.push_back('{to_bcd(i), 1'b0, cyc + 8});
         if (i == 255) start3 = 1'b0;
         repeat (8) @(posedge clk);
         #1;
      end
      repeat (4) @(posedge clk);

      #1 fin_req = 1'b1;
      repeat (4) @(posedge clk);
      if (!fin_done) $display("FAIL final_check: drain check did not run");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
